// File: rtl/hazard_controller.sv
// hazard_controller
// Pipeline sequencing controller for the 5-stage core. Every cycle it decides
// whether each pipeline register advances, holds or is squashed. It covers
// load-use hazards, taken-branch redirects and multi-cycle data-memory
// accesses. It also runs a watchdog on memory waits and keeps saturating
// stall/flush performance counters.
module hazard_controller #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [4:0]       rs1_IF_ID,
    input  logic [4:0]       rs2_IF_ID,
    input  logic             use_rs2_IF_ID,
    input  logic [4:0]       rd_ID_EXE,
    input  logic             mem_read_ID_EXE,
    input  logic             branch_taken_EXE,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_exe_en,
    output logic             exe_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_exe_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // The wait counter only has to reach MAX_WAIT-1 before ERROR takes over.
    localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [WAIT_W-1:0]  wait_cnt_r;
    logic [WAIT_W-1:0]  wait_cnt_s;
    logic               mem_timeout_r;
    logic [CNT_W-1:0]   stall_cnt_r;
    logic [CNT_W-1:0]   flush_cnt_r;
    logic               freeze_s;
    logic               load_use_s;
    logic               stall_qual_s;
    logic               flush_qual_s;

    // Saturating increment: the counter stays at all-ones and never wraps.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    // Hazard terms that forwarding cannot cover.
    always_comb begin
        freeze_s   = dmem_req & ~dmem_ready;
        load_use_s = mem_read_ID_EXE & (rd_ID_EXE != 5'd0) &
                     ((rd_ID_EXE == rs1_IF_ID) |
                      (use_rs2_IF_ID & (rd_ID_EXE == rs2_IF_ID)));
    end

    // State, wait counter and sticky timeout flag.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r       <= ST_RUN;
            wait_cnt_r    <= '0;
            mem_timeout_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
            if (state_s == ST_ERROR) begin
                mem_timeout_r <= 1'b1;
            end else begin
                mem_timeout_r <= mem_timeout_r;
            end
        end
    end

    // Next state and wait counter. A freeze that has already lasted
    // MAX_WAIT-1 cycles ends the wait in ERROR. Only reset leaves ERROR.
    always_comb begin
        state_s    = state_r;
        wait_cnt_s = '0;
        case (state_r)
            ST_RUN, ST_MEM_WAIT: begin
                if (freeze_s) begin
                    if (wait_cnt_r == WAIT_LAST) begin
                        state_s    = ST_ERROR;
                        wait_cnt_s = '0;
                    end else begin
                        state_s    = ST_MEM_WAIT;
                        wait_cnt_s = wait_cnt_r + WAIT_W'(1);
                    end
                end else begin
                    state_s    = ST_RUN;
                    wait_cnt_s = '0;
                end
            end
            ST_ERROR: begin
                state_s    = ST_ERROR;
                wait_cnt_s = '0;
            end
            default: begin
                state_s    = ST_ERROR;
                wait_cnt_s = '0;
            end
        endcase
    end

    // Enable/flush pins in priority order. Reset forces every pin quiet.
    always_comb begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_exe_en    = 1'b0;
        exe_mem_en   = 1'b0;
        mem_wb_en    = 1'b0;
        if_id_flush  = 1'b0;
        id_exe_flush = 1'b0;
        if (!arst_n) begin
            pc_en = 1'b0;
        end else begin
            case (state_r)
                ST_RUN, ST_MEM_WAIT: begin
                    if (freeze_s) begin
                        pc_en = 1'b0;
                    end else if (branch_taken_EXE) begin
                        // The load_use instruction, if any, is squashed by the redirect.
                        pc_en        = 1'b1;
                        if_id_en     = 1'b1;
                        id_exe_en    = 1'b1;
                        exe_mem_en   = 1'b1;
                        mem_wb_en    = 1'b1;
                        if_id_flush  = 1'b1;
                        id_exe_flush = 1'b1;
                    end else if (load_use_s) begin
                        // One bubble, because the load reaches MEM next cycle.
                        id_exe_en    = 1'b1;
                        exe_mem_en   = 1'b1;
                        mem_wb_en    = 1'b1;
                        id_exe_flush = 1'b1;
                    end else begin
                        pc_en      = 1'b1;
                        if_id_en   = 1'b1;
                        id_exe_en  = 1'b1;
                        exe_mem_en = 1'b1;
                        mem_wb_en  = 1'b1;
                    end
                end
                ST_ERROR: begin
                    pc_en = 1'b0;
                end
                default: begin
                    pc_en = 1'b0;
                end
            endcase
        end
    end

    // Which cycles count as a stall and which count as a branch flush.
    always_comb begin
        stall_qual_s = (state_r != ST_ERROR) & ~pc_en;
        flush_qual_s = (state_r != ST_ERROR) & ~freeze_s & branch_taken_EXE;
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stall_cnt_r <= '0;
            flush_cnt_r <= '0;
        end else begin
            if (stall_qual_s) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush_qual_s) begin
                flush_cnt_r <= sat_inc(flush_cnt_r);
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign mem_timeout = mem_timeout_r;
    assign stall_cnt   = stall_cnt_r;
    assign flush_cnt   = flush_cnt_r;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller (MAX_WAIT=4, CNT_W=4).
module tb_hazard_controller;

    logic       clk;
    logic       arst_n;
    logic [4:0] rs1_IF_ID;
    logic [4:0] rs2_IF_ID;
    logic       use_rs2_IF_ID;
    logic [4:0] rd_ID_EXE;
    logic       mem_read_ID_EXE;
    logic       branch_taken_EXE;
    logic       dmem_req;
    logic       dmem_ready;
    logic       pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en;
    logic       if_id_flush, id_exe_flush;
    logic       mem_timeout;
    logic [3:0] stall_cnt;
    logic [3:0] flush_cnt;

    logic [4:0] en;
    logic [1:0] fl;
    int n_vec;
    int n_err;

    assign en = {pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en};
    assign fl = {if_id_flush, id_exe_flush};

    hazard_controller #(.MAX_WAIT(4), .CNT_W(4)) dut (
        .clk(clk), .arst_n(arst_n),
        .rs1_IF_ID(rs1_IF_ID), .rs2_IF_ID(rs2_IF_ID), .use_rs2_IF_ID(use_rs2_IF_ID),
        .rd_ID_EXE(rd_ID_EXE), .mem_read_ID_EXE(mem_read_ID_EXE),
        .branch_taken_EXE(branch_taken_EXE),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_exe_en(id_exe_en),
        .exe_mem_en(exe_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_exe_flush(id_exe_flush),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        rs1_IF_ID        = 5'd0;
        rs2_IF_ID        = 5'd0;
        use_rs2_IF_ID    = 1'b0;
        rd_ID_EXE        = 5'd0;
        mem_read_ID_EXE  = 1'b0;
        branch_taken_EXE = 1'b0;
        dmem_req         = 1'b0;
        dmem_ready       = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        idle_inputs();
        arst_n = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        @(negedge clk);
        arst_n = 1'b0;
        branch_taken_EXE = 1'b1;
        #1;
        n_vec++; if ({en, fl} !== 7'b0) begin n_err++; $display("FAIL reset_pins got=%b exp=%b", {en, fl}, 7'b0); end
        n_vec++; if ({mem_timeout, stall_cnt, flush_cnt} !== 9'b0) begin n_err++; $display("FAIL reset_regs got=%b exp=%b", {mem_timeout, stall_cnt, flush_cnt}, 9'b0); end
        idle_inputs();
        @(negedge clk);
        arst_n = 1'b1;
        step();
        #1;
        n_vec++; if ({en, fl} !== 7'b11111_00) begin n_err++; $display("FAIL reset_release got=%b exp=%b", {en, fl}, 7'b11111_00); end
    endtask

    task automatic test_load_use();
        apply_reset();
        mem_read_ID_EXE = 1'b1; rd_ID_EXE = 5'd5; rs1_IF_ID = 5'd5;
        #1;
        n_vec++; if ({en, fl} !== 7'b00111_01) begin n_err++; $display("FAIL load_use got=%b exp=%b", {en, fl}, 7'b00111_01); end
        step();
        mem_read_ID_EXE = 1'b0;
        #1;
        n_vec++; if ({en, fl} !== 7'b11111_00) begin n_err++; $display("FAIL load_use_after got=%b exp=%b", {en, fl}, 7'b11111_00); end
        n_vec++; if (stall_cnt !== 4'd1) begin n_err++; $display("FAIL load_use_cnt got=%0d exp=%0d", stall_cnt, 1); end
    endtask

    task automatic test_x0_rs2();
        apply_reset();
        mem_read_ID_EXE = 1'b1; rd_ID_EXE = 5'd0; rs1_IF_ID = 5'd0;
        #1;
        n_vec++; if (en !== 5'b11111) begin n_err++; $display("FAIL x0_no_stall got=%b exp=%b", en, 5'b11111); end
        rd_ID_EXE = 5'd7; rs1_IF_ID = 5'd3; rs2_IF_ID = 5'd7; use_rs2_IF_ID = 1'b0;
        #1;
        n_vec++; if (en !== 5'b11111) begin n_err++; $display("FAIL rs2_unused got=%b exp=%b", en, 5'b11111); end
        use_rs2_IF_ID = 1'b1;
        #1;
        n_vec++; if ({en, fl} !== 7'b00111_01) begin n_err++; $display("FAIL rs2_used got=%b exp=%b", {en, fl}, 7'b00111_01); end
        step();
        idle_inputs();
        #1;
        n_vec++; if (stall_cnt !== 4'd1) begin n_err++; $display("FAIL rs2_cnt got=%0d exp=%0d", stall_cnt, 1); end
    endtask

    task automatic test_branch();
        apply_reset();
        branch_taken_EXE = 1'b1;
        mem_read_ID_EXE = 1'b1; rd_ID_EXE = 5'd9; rs1_IF_ID = 5'd9;
        #1;
        n_vec++; if ({en, fl} !== 7'b11111_11) begin n_err++; $display("FAIL branch got=%b exp=%b", {en, fl}, 7'b11111_11); end
        step();
        idle_inputs();
        #1;
        n_vec++; if ({flush_cnt, stall_cnt} !== {4'd1, 4'd0}) begin n_err++; $display("FAIL branch_cnt flush/stall got=%0d/%0d exp=1/0", flush_cnt, stall_cnt); end
    endtask

    task automatic test_mem_wait();
        apply_reset();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            branch_taken_EXE = (i == 1) ? 1'b1 : 1'b0;
            #1;
            n_vec++; if ({en, fl} !== 7'b0) begin n_err++; $display("FAIL mem_wait_hold%0d got=%b exp=%b", i, {en, fl}, 7'b0); end
            step();
        end
        branch_taken_EXE = 1'b0;
        dmem_ready = 1'b1;
        #1;
        n_vec++; if ({en, fl} !== 7'b11111_00) begin n_err++; $display("FAIL mem_wait_release got=%b exp=%b", {en, fl}, 7'b11111_00); end
        step();
        idle_inputs();
        #1;
        n_vec++; if ({mem_timeout, stall_cnt, flush_cnt} !== {1'b0, 4'd3, 4'd0}) begin n_err++; $display("FAIL mem_wait_regs got=%b exp=%b", {mem_timeout, stall_cnt, flush_cnt}, {1'b0, 4'd3, 4'd0}); end
        n_vec++; if (en !== 5'b11111) begin n_err++; $display("FAIL mem_wait_run got=%b exp=%b", en, 5'b11111); end
    endtask

    task automatic test_timeout();
        apply_reset();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_vec++; if (en !== 5'b0) begin n_err++; $display("FAIL timeout_hold%0d got=%b exp=%b", i, en, 5'b0); end
            step();
            n_vec++; if (mem_timeout !== ((i == 3) ? 1'b1 : 1'b0)) begin n_err++; $display("FAIL timeout_flag%0d got=%b exp=%b", i, mem_timeout, (i == 3)); end
        end
        dmem_ready = 1'b1;
        #1;
        n_vec++; if ({en, fl} !== 7'b0) begin n_err++; $display("FAIL error_ready got=%b exp=%b", {en, fl}, 7'b0); end
        step();
        idle_inputs();
        #1;
        n_vec++; if ({en, mem_timeout, stall_cnt} !== {5'b0, 1'b1, 4'd4}) begin n_err++; $display("FAIL error_idle got=%b exp=%b", {en, mem_timeout, stall_cnt}, {5'b0, 1'b1, 4'd4}); end
        step();
        arst_n = 1'b0;
        #1;
        n_vec++; if ({mem_timeout, stall_cnt, flush_cnt} !== 9'b0) begin n_err++; $display("FAIL error_reset got=%b exp=%b", {mem_timeout, stall_cnt, flush_cnt}, 9'b0); end
        @(negedge clk);
        arst_n = 1'b1;
        step();
        #1;
        n_vec++; if (en !== 5'b11111) begin n_err++; $display("FAIL error_reset_run got=%b exp=%b", en, 5'b11111); end
    endtask

    task automatic test_saturation();
        apply_reset();
        mem_read_ID_EXE = 1'b1; rd_ID_EXE = 5'd12; rs1_IF_ID = 5'd12;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 14 || i == 15 || i == 20) begin
                n_vec++;
                if (stall_cnt !== ((i == 14) ? 4'd14 : 4'hF)) begin
                    n_err++; $display("FAIL saturate%0d got=%0d exp=%0d", i, stall_cnt, (i == 14) ? 14 : 15);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        mem_read_ID_EXE = 1'b1; rd_ID_EXE = 5'd4; rs1_IF_ID = 5'd4;
        #1;
        n_vec++; if ({en, fl} !== 7'b00111_01) begin n_err++; $display("FAIL b2b_stall got=%b exp=%b", {en, fl}, 7'b00111_01); end
        step();
        mem_read_ID_EXE = 1'b0; branch_taken_EXE = 1'b1;
        #1;
        n_vec++; if ({en, fl} !== 7'b11111_11) begin n_err++; $display("FAIL b2b_branch got=%b exp=%b", {en, fl}, 7'b11111_11); end
        step();
        idle_inputs();
        #1;
        n_vec++; if ({stall_cnt, flush_cnt} !== {4'd1, 4'd1}) begin n_err++; $display("FAIL b2b_cnt got=%b exp=%b", {stall_cnt, flush_cnt}, {4'd1, 4'd1}); end
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        arst_n = 1'b1;
        idle_inputs();
        test_reset();
        test_load_use();
        test_x0_rs2();
        test_branch();
        test_mem_wait();
        test_saturation();
        test_back_to_back();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
